// File: rtl/parity_scan_engine_if.sv
// Bus bundle for parity_scan_engine: write port, scan control and scan results.
interface parity_scan_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) ();
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_parity;
    logic              start;
    logic              odd_mode;
    logic              busy;
    logic              done;
    logic              chk_valid;
    logic              chk_match;
    logic [ADDR_W-1:0] chk_addr;
    logic [ADDR_W:0]   err_count;
    logic              first_err_valid;
    logic [ADDR_W-1:0] first_err_addr;

    modport master (
        output wr_en, wr_addr, wr_data, wr_parity, start, odd_mode,
        input  busy, done, chk_valid, chk_match, chk_addr,
               err_count, first_err_valid, first_err_addr
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_parity, start, odd_mode,
        output busy, done, chk_valid, chk_match, chk_addr,
               err_count, first_err_valid, first_err_addr
    );
endinterface

// File: rtl/parity_scan_engine.sv
// Parity-protected memory scanner: sweeps every word, checks stored parity under
// a per-scan even/odd mode, and reports per-word matches, error count and first failure.
module parity_scan_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    parity_scan_engine_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state, state_nx;

    logic [DATA_W:0]   mem [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic              mode;
    logic              chk_valid;
    logic              chk_match;
    logic [ADDR_W-1:0] chk_addr;
    logic [ADDR_W:0]   err_count;
    logic              first_err_valid;
    logic [ADDR_W-1:0] first_err_addr;

    logic [DATA_W:0]   rd_word;
    logic              rd_match;

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (bus.wr_en && state == IDLE)
            mem[bus.wr_addr] <= {bus.wr_data, bus.wr_parity};
    end

    always_comb begin
        rd_word  = mem[addr];
        rd_match = (rd_word[0] == ((^rd_word[DATA_W:1]) ^ mode));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SCAN;
            SCAN:    if (addr == '1) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr            <= '0;
            mode            <= 1'b0;
            chk_valid       <= 1'b0;
            chk_match       <= 1'b0;
            chk_addr        <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else begin
            // Result window spans the SCAN cycles, so the last word lands alongside done.
            chk_valid <= (state == SCAN);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr            <= '0;
                        mode            <= bus.odd_mode;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_addr  <= '0;
                    end
                end
                SCAN: begin
                    chk_addr  <= addr;
                    chk_match <= rd_match;
                    if (!rd_match) begin
                        err_count <= err_count + CNT_ONE;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_addr  <= addr;
                        end
                    end
                    addr <= addr + ADDR_ONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy            = (state == SCAN);
    assign bus.done            = (state == DONE);
    assign bus.chk_valid       = chk_valid;
    assign bus.chk_match       = chk_match;
    assign bus.chk_addr        = chk_addr;
    assign bus.err_count       = err_count;
    assign bus.first_err_valid = first_err_valid;
    assign bus.first_err_addr  = first_err_addr;
endmodule

// File: tb/tb_parity_scan_engine.sv
// Self-checking bench for parity_scan_engine against a word-level parity model.
module tb_parity_scan_engine;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [DATA_W:0] mem_m [DEPTH];

    parity_scan_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    parity_scan_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected stored bit is the data's ones-count parity, inverted in odd mode.
    function automatic bit exp_match(input int a, input logic m);
        int ones;
        ones = $countones(mem_m[a][DATA_W:1]);
        return mem_m[a][0] == (((ones % 2) == 1) ^ m);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_done"},  32'(bus.done), 0);
        check({tag, "_valid"}, 32'(bus.chk_valid), 0);
        check({tag, "_match"}, 32'(bus.chk_match), 0);
        check({tag, "_addr"},  32'(bus.chk_addr), 0);
        check({tag, "_errc"},  32'(bus.err_count), 0);
        check({tag, "_fev"},   32'(bus.first_err_valid), 0);
        check({tag, "_fea"},   32'(bus.first_err_addr), 0);
    endtask

    task automatic write_word(input int a, input logic [DATA_W-1:0] d, input logic p);
        bus.wr_en     = 1'b1;
        bus.wr_addr   = ADDR_W'(a);
        bus.wr_data   = d;
        bus.wr_parity = p;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        mem_m[a] = {d, p};
    endtask

    task automatic do_scan(input logic mode, input bit disturb, input int abort_at);
        int exp_err;
        int exp_first;
        exp_err   = 0;
        exp_first = -1;
        for (int a = 0; a < DEPTH; a++) begin
            if (!exp_match(a, mode)) begin
                exp_err++;
                if (exp_first < 0) exp_first = a;
            end
        end
        bus.start    = 1'b1;
        bus.odd_mode = mode;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_e0",  32'(bus.busy), 1);
        check("done_e0",  32'(bus.done), 0);
        check("valid_e0", 32'(bus.chk_valid), 0);
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            check("valid", 32'(bus.chk_valid), 1);
            check("addr",  32'(bus.chk_addr), 32'(i));
            check("match", 32'(bus.chk_match), 32'(exp_match(i, mode)));
            check("busy",  32'(bus.busy), 32'(i != DEPTH - 1));
            check("done",  32'(bus.done), 32'(i == DEPTH - 1));
            if (i == abort_at) begin
                #2 reset = 1'b0;
                #1 check_reset("midrst");
                #2 reset = 1'b1;
                return;
            end
            if (disturb) begin
                if (i == 7) begin
                    bus.start     = 1'b1;
                    bus.odd_mode  = ~mode;
                    bus.wr_en     = 1'b1;
                    bus.wr_addr   = '0;
                    bus.wr_data   = ~mem_m[0][DATA_W:1];
                    bus.wr_parity = ~mem_m[0][0];
                end else if (i == 8) begin
                    bus.start = 1'b0;
                    bus.wr_en = 1'b0;
                end
                if (i == DEPTH - 1) bus.start = 1'b1;
            end
        end
        check("err_count", 32'(bus.err_count), 32'(exp_err));
        check("first_v",   32'(bus.first_err_valid), 32'(exp_err != 0));
        check("first_a",   32'(bus.first_err_addr), exp_first < 0 ? 0 : 32'(exp_first));
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.odd_mode = 1'b0;
        check("post_busy",  32'(bus.busy), 0);
        check("post_done",  32'(bus.done), 0);
        check("post_valid", 32'(bus.chk_valid), 0);
        check("post_errc",  32'(bus.err_count), 32'(exp_err));
        if (disturb) begin
            @(posedge clk); #1;
            check("no_restart", 32'(bus.busy), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] d;
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.wr_parity = 1'b0;
        bus.start     = 1'b0;
        bus.odd_mode  = 1'b0;
        #3 check_reset("por");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            d = DATA_W'(17 * i);
            write_word(i, d, ^d);
        end
        do_scan(1'b0, 1'b0, -1);

        write_word(3, mem_m[3][DATA_W:1], ~mem_m[3][0]);
        write_word(9, mem_m[9][DATA_W:1], ~mem_m[9][0]);
        do_scan(1'b0, 1'b0, -1);
        check("corrupt_cnt", 32'(bus.err_count), 2);

        do_scan(1'b1, 1'b1, -1);
        check("odd_cnt", 32'(bus.err_count), 14);
        do_scan(1'b1, 1'b0, -1);

        do_scan(1'b0, 1'b0, 5);
        @(posedge clk); #1;
        check("after_rst_busy", 32'(bus.busy), 0);
        do_scan(1'b0, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < DEPTH; a++)
                write_word(a, DATA_W'($urandom), 1'($urandom));
            do_scan(1'($urandom), 1'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
